// File: rtl/data_mem_mmio.sv
// data_mem_mmio
//   Data-side responder for the pipelined core's memory port. Combinational
//   reads, writes commit on the rising clock edge. Holds a word-addressed data
//   RAM and an I/O page with LED, switch, cycle-counter and TX FIFO registers.
//
//   I/O page (byte offsets from MMIO_BASE):
//     +0x00 LED    RW   +0x04 SW    RO   +0x08 CYCLE RW (write clears)
//     +0x0C TXDATA WO   +0x10 TXSTAT RW (read: {count[15:8], ovf, full, empty},
//                                        write: clears overflow)
//
// Ports
//   CLK        clock, all state on posedge
//   Reset      synchronous, active-high
//   MemWrite   write strobe for the current address
//   OpResult   byte address, bits[1:0] ignored
//   WriteData  store data
//   ReadData   load data, combinational on OpResult
//   Switches   asynchronous board switches
//   LED        LED register
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts head when tx_valid & tx_ready
module data_mem_mmio #(
    parameter logic [31:0] DATA_BASE  = 32'h0000_0800,
    parameter int          DATA_WORDS = 128,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0C00,
    parameter int          LED_W      = 16,
    parameter int          SW_W       = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWrite,
    input  logic [31:0]       OpResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [SW_W-1:0]   Switches,
    output logic [LED_W-1:0]  LED,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int          RAM_AW   = $clog2(DATA_WORDS);
    localparam int          FIFO_AW  = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = FIFO_AW + 1;
    localparam logic [31:0] DATA_END = DATA_BASE + 32'(4 * DATA_WORDS);

    // ------------------------------------------------------------------
    // Address decode (word granular)
    // ------------------------------------------------------------------
    logic [31:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              hit_ram, hit_led, hit_sw, hit_cycle, hit_txdata, hit_txstat;

    assign word_addr  = OpResult & ~32'h3;
    assign hit_ram    = (word_addr >= DATA_BASE) && (word_addr < DATA_END);
    assign ram_idx    = RAM_AW'((word_addr - DATA_BASE) >> 2);
    assign hit_led    = (word_addr == MMIO_BASE);
    assign hit_sw     = (word_addr == MMIO_BASE + 32'h04);
    assign hit_cycle  = (word_addr == MMIO_BASE + 32'h08);
    assign hit_txdata = (word_addr == MMIO_BASE + 32'h0C);
    assign hit_txstat = (word_addr == MMIO_BASE + 32'h10);

    // ------------------------------------------------------------------
    // Data RAM: asynchronous read, synchronous write
    // ------------------------------------------------------------------
    logic [31:0] ram [DATA_WORDS];

    // NOTE: memory arrays carry no reset so they map onto RAM macros;
    // contents survive Reset.
    always_ff @(posedge CLK) begin
        if (MemWrite && hit_ram)
            ram[ram_idx] <= WriteData;
    end

    // ------------------------------------------------------------------
    // Registers and TX FIFO control
    // ------------------------------------------------------------------
    logic [LED_W-1:0]   led_q;
    logic [SW_W-1:0]    sw_meta, sw_sync;
    logic [31:0]        cycle_q;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               overflow;
    logic               fifo_empty, fifo_full;
    logic               push_req, push_ok, pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = tx_valid && tx_ready;
    assign push_req   = MemWrite && hit_txdata;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push_req && (!fifo_full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            led_q      <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            cycle_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            sw_meta <= Switches;
            sw_sync <= sw_meta;

            if (MemWrite && hit_led)
                led_q <= WriteData[LED_W-1:0];

            // Write clears; clear wins over the increment.
            if (MemWrite && hit_cycle)
                cycle_q <= '0;
            else
                cycle_q <= cycle_q + 32'd1;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (MemWrite && hit_txstat)
                overflow <= 1'b0;
            else if (push_req && !push_ok)
                overflow <= 1'b1;
        end
    end

    // FIFO storage; a push in a Reset cycle is discarded.
    always_ff @(posedge CLK) begin
        if (!Reset && push_ok)
            fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    assign LED      = led_q;
    assign tx_data  = fifo_mem[rd_ptr];
    assign tx_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ReadData = '0;
        if (hit_ram)
            ReadData = ram[ram_idx];
        else if (hit_led)
            ReadData = 32'(led_q);
        else if (hit_sw)
            ReadData = 32'(sw_sync);
        else if (hit_cycle)
            ReadData = cycle_q;
        else if (hit_txstat)
            ReadData = {16'h0, 8'(fifo_count), 5'b0, overflow, fifo_full, fifo_empty};
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio
//   Directed bench for data_mem_mmio: RAM, LED, switch sync, cycle counter,
//   TX FIFO ordering/overflow/simultaneous push-pop and mid-transfer reset.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   before the next edge.
module tb_data_mem_mmio;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] OpResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] Switches;
    logic [15:0] LED;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    data_mem_mmio dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemWrite  (MemWrite),
        .OpResult  (OpResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Switches  (Switches),
        .LED       (LED),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] expected, input string tag);
        MemWrite = 1'b0;
        OpResult = addr;
        #1;
        check(tag, ReadData, expected);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        OpResult  = addr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        MemWrite  = 1'b0;
        OpResult  = '0;
        WriteData = '0;
        Switches  = '0;
        tx_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_led", 32'(LED), 32'h0);
        rd(32'h0C10, 32'h0000_0001, "rst_txstat");

        // Cycle counter: 0 in the first cycle after reset, then +1 per edge
        Reset = 1'b0;
        rd(32'h0C08, 32'd0, "cycle_n0");
        repeat (5) tick();
        rd(32'h0C08, 32'd5, "cycle_n5");
        wr(32'h0C08, 32'h0000_0123);
        rd(32'h0C08, 32'd0, "cycle_clr");
        tick();
        rd(32'h0C08, 32'd1, "cycle_after_clr");

        // RAM
        wr(32'h0804, 32'hDEAD_BEEF);
        rd(32'h0804, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h0807, 32'hDEAD_BEEF, "ram_rd_unaligned");
        MemWrite  = 1'b1;
        OpResult  = 32'h0804;
        WriteData = 32'h1111_1111;
        #1;
        check("ram_old_word_on_write", ReadData, 32'hDEAD_BEEF);
        tick();
        MemWrite = 1'b0;
        rd(32'h0804, 32'h1111_1111, "ram_new_word");
        wr(32'h09FC, 32'hCAFE_0001);
        rd(32'h09FC, 32'hCAFE_0001, "ram_last_word");
        rd(32'h0A00, 32'h0, "ram_past_end");
        rd(32'h1000, 32'h0, "unmapped_rd");
        wr(32'h1000, 32'hFFFF_FFFF);
        rd(32'h0804, 32'h1111_1111, "unmapped_wr_ram");
        check("unmapped_wr_led", 32'(LED), 32'h0);
        rd(32'h1000, 32'h0, "unmapped_wr_rd");

        // LED
        wr(32'h0C00, 32'h1234_ABCD);
        check("led_out", 32'(LED), 32'h0000_ABCD);
        rd(32'h0C00, 32'h0000_ABCD, "led_rd");

        // Switch synchronizer: visible only from the 2nd edge on
        Switches = 16'h00F0;
        rd(32'h0C04, 32'h0, "sw_edge0");
        tick();
        rd(32'h0C04, 32'h0, "sw_edge1");
        tick();
        rd(32'h0C04, 32'h0000_00F0, "sw_edge2");

        // TXDATA reads as 0
        rd(32'h0C0C, 32'h0, "txdata_rd");

        // FIFO fill, overflow, drain in order
        tx_ready = 1'b0;
        wr(32'h0C0C, 32'h0000_0041);
        check("fifo_valid_after_push", 32'(tx_valid), 32'h1);
        check("fifo_head_41", 32'(tx_data), 32'h41);
        wr(32'h0C0C, 32'h0000_0042);
        wr(32'h0C0C, 32'h0000_0043);
        wr(32'h0C0C, 32'h0000_0044);
        rd(32'h0C10, 32'h0000_0402, "fifo_full_stat");
        wr(32'h0C0C, 32'h0000_0045);
        rd(32'h0C10, 32'h0000_0406, "fifo_overflow_stat");
        check("fifo_head_kept", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        #1;
        check("drain_0", 32'(tx_data), 32'h41);
        tick();
        check("drain_1", 32'(tx_data), 32'h42);
        tick();
        check("drain_2", 32'(tx_data), 32'h43);
        tick();
        check("drain_3", 32'(tx_data), 32'h44);
        tick();
        check("drain_empty", 32'(tx_valid), 32'h0);
        rd(32'h0C10, 32'h0000_0005, "empty_ovf_sticky");
        wr(32'h0C10, 32'h0000_0000);
        rd(32'h0C10, 32'h0000_0001, "ovf_cleared");

        // Full FIFO with simultaneous pop accepts the push
        tx_ready = 1'b0;
        wr(32'h0C0C, 32'h0000_0050);
        wr(32'h0C0C, 32'h0000_0051);
        wr(32'h0C0C, 32'h0000_0052);
        wr(32'h0C0C, 32'h0000_0053);
        tx_ready = 1'b1;
        wr(32'h0C0C, 32'h0000_0055);
        tx_ready = 1'b0;
        rd(32'h0C10, 32'h0000_0402, "simul_stat");
        check("simul_head", 32'(tx_data), 32'h51);
        tx_ready = 1'b1;
        tick();
        check("simul_1", 32'(tx_data), 32'h52);
        tick();
        check("simul_2", 32'(tx_data), 32'h53);
        tick();
        check("simul_3", 32'(tx_data), 32'h55);
        tick();
        check("simul_empty", 32'(tx_valid), 32'h0);

        // Reset mid-transfer with a pending push and pop
        tx_ready = 1'b0;
        wr(32'h0C0C, 32'h0000_0061);
        wr(32'h0C0C, 32'h0000_0062);
        wr(32'h0C0C, 32'h0000_0063);
        rd(32'h0C10, 32'h0000_0300, "pre_reset_count");
        tx_ready  = 1'b1;
        Reset     = 1'b1;
        MemWrite  = 1'b1;
        OpResult  = 32'h0C0C;
        WriteData = 32'h0000_0064;
        tick();
        Reset    = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("rst2_tx_valid", 32'(tx_valid), 32'h0);
        check("rst2_led", 32'(LED), 32'h0);
        rd(32'h0C10, 32'h0000_0001, "rst2_txstat");
        rd(32'h0C08, 32'd0, "rst2_cycle");
        rd(32'h0804, 32'h1111_1111, "rst2_ram_kept");
        rd(32'h09FC, 32'hCAFE_0001, "rst2_ram_last_kept");
        rd(32'h0C04, 32'h0, "rst2_sw_cleared");
        tick();
        rd(32'h0C08, 32'd1, "rst2_cycle_next");
        check("rst2_push_discarded", 32'(tx_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
